edge_result_writer: RTL and testbench

Write-side counterpart of the Sobel processing path. It takes the 1-bit-per-pixel edge stream produced by the processor and packs it LSB-first into bytes. It writes those bytes into an output frame memory at sequential byte addresses and signals completion. Border columns (first and last of each row) are forced to 0, because the 3x3 window is not valid there.

---
 rtl/edge_pkg.sv | 21 ++
 rtl/edge_result_writer_bit_packer.sv | 55 +++++
 rtl/edge_result_writer.sv | 149 ++++++++++++++
 tb/tb_edge_result_writer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// edge_pkg: shared types and constants for the Sobel edge write path.
//   state_e          - capture FSM states
//   DefaultW         - default image width in pixels
//   DefaultLength    - default pixels per frame (W*H)
//   bytes_per_frame  - ceil(length/8), number of packed bytes per frame
package edge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDone
  } state_e;

  localparam int unsigned DefaultW      = 224;
  localparam int unsigned DefaultLength = 50176;

  function automatic int unsigned bytes_per_frame(input int unsigned length);
    return (length + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/edge_result_writer_bit_packer.sv
// bit_packer: LSB-first 8-bit pack register with its bit counter.
//   clk_i        - clock
//   rst_i        - asynchronous active-high reset
//   clear_i      - synchronous clear of register and counter (frame start)
//   load_i       - accept bit_i into position bit_cnt
//   bit_i        - bit to pack
//   last_i       - this load is the final bit of the frame (forces emit)
//   byte_ready_o - the current load completes a byte
//   byte_out_o   - completed byte including bit_i, unfilled high bits 0
module bit_packer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic       bit_i,
  input  logic       last_i,
  output logic       byte_ready_o,
  output logic [7:0] byte_out_o
);

  logic [7:0] pack_q, pack_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  // Bits above bit_cnt are always 0, so OR-ing in the new bit yields a zero-padded byte.
  assign byte_out_o   = pack_q | (8'(bit_i) << bit_cnt_q);
  assign byte_ready_o = load_i && ((bit_cnt_q == 3'd7) || last_i);

  always_comb begin
    pack_d    = pack_q;
    bit_cnt_d = bit_cnt_q;
    if (clear_i) begin
      pack_d    = 8'h00;
      bit_cnt_d = 3'd0;
    end else if (load_i) begin
      if (byte_ready_o) begin
        pack_d    = 8'h00;
        bit_cnt_d = 3'd0;
      end else begin
        pack_d    = byte_out_o;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pack_q    <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      pack_q    <= pack_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/edge_result_writer.sv
// edge_result_writer: packs the 1-bit Sobel edge stream LSB-first into bytes and writes
// them to an output frame memory at sequential byte addresses. First/last columns of
// every row are forced to 0.
//   clk_i       - clock, rising edge
//   rst_i       - asynchronous active-high reset, aborts a frame in progress
//   start_i     - frame start (sampled in IDLE/DONE only)
//   in_valid_i  - in_bit_i carries a pixel result this cycle
//   in_bit_i    - edge result, 1 = edge
//   mem_we_o    - one-cycle write strobe
//   mem_addr_o  - byte address of the write
//   mem_data_o  - packed byte, bit k = pixel 8*addr+k
//   busy_o      - capture in progress
//   done_o      - frame complete, held until next start or reset
module edge_result_writer
  import edge_pkg::*;
#(
  parameter int unsigned W      = DefaultW,
  parameter int unsigned LENGTH = DefaultLength,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic              in_bit_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned PixW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned ColW = (W > 1) ? $clog2(W) : 1;
  localparam logic [PixW-1:0] LastPix = PixW'(LENGTH - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(W - 1);

  state_e            state_q, state_d;
  logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [ColW-1:0]   col_cnt_q, col_cnt_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic       accept;
  logic       last_pix;
  logic       masked_bit;
  logic       pk_clear;
  logic       byte_ready;
  logic [7:0] byte_out;

  assign last_pix = (pix_cnt_q == LastPix);
  // The 3x3 window is not valid on the border columns.
  assign masked_bit = in_bit_i && (col_cnt_q != '0) && (col_cnt_q != LastCol);

  bit_packer u_bit_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (pk_clear),
    .load_i       (accept),
    .bit_i        (masked_bit),
    .last_i       (last_pix),
    .byte_ready_o (byte_ready),
    .byte_out_o   (byte_out)
  );

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    col_cnt_d  = col_cnt_q;
    byte_cnt_d = byte_cnt_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    accept     = 1'b0;
    pk_clear   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // in_valid is ignored here, even together with start.
        if (start_i) begin
          state_d    = StCapture;
          pix_cnt_d  = '0;
          col_cnt_d  = '0;
          byte_cnt_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pk_clear   = 1'b1;
        end
      end
      StCapture: begin
        if (in_valid_i) begin
          accept    = 1'b1;
          pix_cnt_d = pix_cnt_q + PixW'(1);
          col_cnt_d = (col_cnt_q == LastCol) ? '0 : col_cnt_q + ColW'(1);
          if (byte_ready) begin
            mem_we_d   = 1'b1;
            mem_addr_d = byte_cnt_q;
            mem_data_d = byte_out;
            byte_cnt_d = byte_cnt_q + ADDR_W'(1);
          end
          if (last_pix) begin
            state_d   = StDone;
            pix_cnt_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pix_cnt_q  <= '0;
      col_cnt_q  <= '0;
      byte_cnt_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      col_cnt_q  <= col_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_edge_result_writer.sv
// Self-checking bench: a small instance (W=4, LENGTH=20) for directed scenarios and a
// default-size instance for a full frame. A pixel-index model predicts all outputs.
module tb_edge_result_writer;
  import edge_pkg::*;

  localparam int SW = 4;
  localparam int SL = 20;
  localparam int BW = DefaultW;
  localparam int BL = DefaultLength;
  localparam int BBytes = bytes_per_frame(BL);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance signals
  logic        s_rst = 1'b1, s_start = 1'b0, s_valid = 1'b0, s_bit = 1'b0;
  logic        s_we, s_busy, s_done;
  logic [7:0]  s_addr;
  logic [7:0]  s_data;
  // Big instance signals
  logic        b_rst = 1'b1, b_start = 1'b0, b_valid = 1'b0, b_bit = 1'b0;
  logic        b_we, b_busy, b_done;
  logic [15:0] b_addr;
  logic [7:0]  b_data;

  edge_result_writer #(.W(SW), .LENGTH(SL), .ADDR_W(8)) u_small (
    .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .in_valid_i(s_valid), .in_bit_i(s_bit),
    .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_data_o(s_data), .busy_o(s_busy),
    .done_o(s_done)
  );

  edge_result_writer #(.W(BW), .LENGTH(BL), .ADDR_W(16)) u_big (
    .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .in_valid_i(b_valid), .in_bit_i(b_bit),
    .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_data_o(b_data), .busy_o(b_busy),
    .done_o(b_done)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model in terms of accepted pixel index: pixel p sits at column p%w, bit p%8 of
  // byte p/8; a byte is written once its last pixel (or the frame's last) arrives.
  typedef struct {
    bit       cap;
    int       pcount;
    int       acc;
    bit       we;
    int       addr;
    int       data;
    bit       busy;
    bit       done;
  } model_t;

  function automatic model_t model_next(input model_t m, input bit rst, input bit start,
                                        input bit valid, input bit b, input int w,
                                        input int len);
    model_t n = m;
    int col;
    bit mb;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    n.we = 1'b0;
    if (!m.cap) begin
      if (start) begin
        n.cap = 1'b1; n.pcount = 0; n.acc = 0; n.busy = 1'b1; n.done = 1'b0;
      end
    end else if (valid) begin
      col = m.pcount % w;
      mb  = (col == 0 || col == w - 1) ? 1'b0 : b;
      n.acc = m.acc | (int'(mb) << (m.pcount % 8));
      if (m.pcount % 8 == 7 || m.pcount == len - 1) begin
        n.we = 1'b1; n.addr = m.pcount / 8; n.data = n.acc; n.acc = 0;
      end
      if (m.pcount == len - 1) begin
        n.cap = 1'b0; n.busy = 1'b0; n.done = 1'b1;
      end
      n.pcount = m.pcount + 1;
    end
    return n;
  endfunction

  model_t sm = '{default: 0};
  model_t bm = '{default: 0};

  always @(posedge clk) begin
    sm = model_next(sm, s_rst, s_start, s_valid, s_bit, SW, SL);
    bm = model_next(bm, b_rst, b_start, b_valid, b_bit, BW, BL);
  end

  // Per-cycle compare of both instances, plus write logs.
  int s_log_a[$];
  int s_log_d[$];
  int b_wr_cnt = 0;
  int b_last_addr = -1;
  int b_done_at_last = 0;
  logic [7:0] b_mem [BBytes];

  always @(posedge clk) begin
    #1;
    check("s_we",   int'(s_we),   int'(sm.we));
    check("s_addr", int'(s_addr), sm.addr);
    check("s_data", int'(s_data), sm.data);
    check("s_busy", int'(s_busy), int'(sm.busy));
    check("s_done", int'(s_done), int'(sm.done));
    check("b_we",   int'(b_we),   int'(bm.we));
    check("b_addr", int'(b_addr), bm.addr);
    check("b_data", int'(b_data), bm.data);
    check("b_busy", int'(b_busy), int'(bm.busy));
    check("b_done", int'(b_done), int'(bm.done));
    if (s_we) begin
      s_log_a.push_back(int'(s_addr));
      s_log_d.push_back(int'(s_data));
    end
    if (b_we) begin
      b_wr_cnt++;
      b_last_addr = int'(b_addr);
      if (int'(b_addr) < BBytes) b_mem[b_addr] = b_data;
      b_done_at_last = int'(b_done);
    end
  end

  task automatic s_cyc(input bit st, input bit v, input bit b);
    @(negedge clk);
    s_start = st; s_valid = v; s_bit = b;
  endtask

  task automatic s_idle(input int n);
    for (int i = 0; i < n; i++) s_cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_log(input string name, input int d0, input int d1, input int d2);
    int exp_d[3];
    exp_d = '{d0, d1, d2};
    check({name, "_count"}, s_log_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < s_log_a.size()) begin
        check({name, "_addr"}, s_log_a[i], i);
        check({name, "_data"}, s_log_d[i], exp_d[i]);
      end
    end
    s_log_a.delete();
    s_log_d.delete();
  endtask

  initial begin
    int n;
    int cyc;
    // Reset
    repeat (2) @(negedge clk);
    check("reset_we", int'(s_we), 0);
    check("reset_addr", int'(s_addr), 0);
    check("reset_busy", int'(s_busy), 0);
    check("reset_done", int'(s_done), 0);
    s_rst = 1'b0; b_rst = 1'b0;
    // in_valid in IDLE is ignored
    for (int i = 0; i < 3; i++) s_cyc(1'b0, 1'b1, 1'b1);

    // Frame A: 20 consecutive ones
    s_cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < SL; i++) s_cyc(1'b0, 1'b1, 1'b1);
    s_idle(3);
    check_log("frameA", 'h66, 'h66, 'h06);
    check("frameA_done", int'(s_done), 1);
    check("frameA_busy", int'(s_busy), 0);
    // in_valid in DONE is ignored
    for (int i = 0; i < 3; i++) s_cyc(1'b0, 1'b1, 1'b1);
    s_idle(1);
    check("done_hold_nowrite", s_log_a.size(), 0);

    // Frame B: random gaps, start pulsed mid-capture
    s_cyc(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("restart_done_low", int'(s_done), 0);
    check("restart_busy", int'(s_busy), 1);
    n = 0; cyc = 0;
    while (n < SL && cyc < 200) begin
      automatic bit v = 1'($urandom_range(0, 1));
      s_cyc((cyc == 5), v, 1'b1);
      if (v) n++;
      cyc++;
    end
    check("frameB_budget", n, SL);
    s_idle(3);
    check_log("frameB", 'h66, 'h66, 'h06);

    // Frame C: start+valid together (dropped), then ones only at pixels 1,2,5,6
    s_cyc(1'b1, 1'b1, 1'b1);
    for (int p = 0; p < SL; p++) s_cyc(1'b0, 1'b1, (p == 1 || p == 2 || p == 5 || p == 6));
    s_idle(3);
    check_log("frameC", 'h66, 'h00, 'h00);

    // Frame D: reset after 10 accepted bits
    s_cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) s_cyc(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    s_rst = 1'b1; s_valid = 1'b1;
    repeat (2) @(negedge clk);
    s_rst = 1'b0;
    for (int i = 0; i < 3; i++) s_cyc(1'b0, 1'b1, 1'b1);
    s_idle(1);
    check("abort_count", s_log_a.size(), 1);
    if (s_log_a.size() > 0) begin
      check("abort_addr", s_log_a[0], 0);
      check("abort_data", s_log_d[0], 'h66);
    end
    check("abort_we", int'(s_we), 0);
    check("abort_addr_out", int'(s_addr), 0);
    check("abort_data_out", int'(s_data), 0);
    check("abort_busy", int'(s_busy), 0);
    check("abort_done", int'(s_done), 0);
    s_log_a.delete();
    s_log_d.delete();
    s_cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < SL; i++) s_cyc(1'b0, 1'b1, 1'b1);
    s_idle(3);
    check_log("frameE", 'h66, 'h66, 'h06);

    // Full default-size frame of ones
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; b_valid = 1'b1; b_bit = 1'b1;
    repeat (BL) @(negedge clk);
    b_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("big_writes", b_wr_cnt, 6272);
    check("big_last_addr", b_last_addr, 6271);
    check("big_done_with_last", b_done_at_last, 1);
    check("big_busy_end", int'(b_busy), 0);
    check("big_byte0", int'(b_mem[0]), 'hFE);
    check("big_byte1", int'(b_mem[1]), 'hFF);
    check("big_byte27", int'(b_mem[27]), 'h7F);
    check("big_byte28", int'(b_mem[28]), 'hFE);
    check("big_byte6271", int'(b_mem[6271]), 'h7F);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
